// File: rtl/mul_wb_buffer_if.sv
// Handshake bundle between issue stage, multiplier and writeback, and the
// in-order multiply completion buffer.
interface mul_wb_buffer_if #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TAG_W = 5
);
  localparam int unsigned OCC_W = $clog2(DEPTH + 1);

  logic             issue_valid;
  logic [TAG_W-1:0] issue_tag;
  logic [1:0]       issue_op;
  logic             issue_ready;
  logic             mul_done;
  logic [1:0]       mul_op;
  logic [63:0]      mul_p;
  logic             wb_valid;
  logic [TAG_W-1:0] wb_tag;
  logic [31:0]      wb_data;
  logic             wb_ack;
  logic [OCC_W-1:0] occupancy;
  logic             op_err;

  modport master (
    output issue_valid, issue_tag, issue_op, mul_done, mul_op, mul_p, wb_ack,
    input  issue_ready, wb_valid, wb_tag, wb_data, occupancy, op_err
  );

  modport slave (
    input  issue_valid, issue_tag, issue_op, mul_done, mul_op, mul_p, wb_ack,
    output issue_ready, wb_valid, wb_tag, wb_data, occupancy, op_err
  );
endinterface

// File: rtl/mul_wb_buffer.sv
// In-order completion buffer behind the non-stalling multiplier; credits gate issue.
// Optional op cross-check on completion: define MUL_WB_OP_CHECK_EN.
module mul_wb_buffer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TAG_W = 5
) (
  input logic            clk,
  input logic            rst_n,
  mul_wb_buffer_if.slave bus
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned OCC_W = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {StFree, StPending, StReady} entry_state_e;

  entry_state_e     state_q [DEPTH];
  entry_state_e     state_d [DEPTH];
  logic [TAG_W-1:0] tag_q   [DEPTH];
  logic [31:0]      data_q  [DEPTH];

  logic [PTR_W-1:0] alloc_q, alloc_d;
  logic [PTR_W-1:0] cmp_q, cmp_d;
  logic [PTR_W-1:0] head_q, head_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic             err_q, err_d;

  logic             issue_fire;
  logic             done_hit;
  logic             pop;
  logic [31:0]      done_data;

  // Explicit wrap so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign bus.issue_ready = (occ_q < OCC_W'(DEPTH));
  assign issue_fire      = bus.issue_valid & bus.issue_ready;
  assign done_hit        = bus.mul_done & (state_q[cmp_q] == StPending);
  assign bus.wb_valid    = (state_q[head_q] == StReady);
  assign pop             = bus.wb_valid & bus.wb_ack;
  assign done_data       = (bus.mul_op == 2'b00) ? bus.mul_p[31:0] : bus.mul_p[63:32];

  assign bus.wb_tag    = tag_q[head_q];
  assign bus.wb_data   = data_q[head_q];
  assign bus.occupancy = occ_q;
  assign bus.op_err    = err_q;

  // Issue, completion and pop always target distinct entries, so no priority is needed.
  always_comb begin
    state_d = state_q;
    alloc_d = alloc_q;
    cmp_d   = cmp_q;
    head_d  = head_q;
    if (issue_fire) begin
      state_d[alloc_q] = StPending;
      alloc_d          = ptr_inc(alloc_q);
    end
    if (done_hit) begin
      state_d[cmp_q] = StReady;
      cmp_d          = ptr_inc(cmp_q);
    end
    if (pop) begin
      state_d[head_q] = StFree;
      head_d          = ptr_inc(head_q);
    end
    occ_d = occ_q + OCC_W'(issue_fire) - OCC_W'(pop);
  end

`ifdef MUL_WB_OP_CHECK_EN
  logic [1:0] op_q [DEPTH];

  always_ff @(posedge clk) begin
    if (issue_fire) op_q[alloc_q] <= bus.issue_op;
  end

  // A stray done (nothing pending) or an op that disagrees with the allocated entry.
  assign err_d = err_q | (bus.mul_done & (~done_hit | (bus.mul_op != op_q[cmp_q])));
`else
  logic unused_op;
  assign unused_op = ^bus.issue_op;
  assign err_d     = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) state_q[i] <= StFree;
      alloc_q <= '0;
      cmp_q   <= '0;
      head_q  <= '0;
      occ_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      alloc_q <= alloc_d;
      cmp_q   <= cmp_d;
      head_q  <= head_d;
      occ_q   <= occ_d;
      err_q   <= err_d;
    end
  end

  // Payload storage needs no reset; entry state qualifies it.
  always_ff @(posedge clk) begin
    if (issue_fire) tag_q[alloc_q] <= bus.issue_tag;
    if (done_hit)   data_q[cmp_q]  <= done_data;
  end
endmodule

// File: tb/tb_mul_wb_buffer.sv
// Directed self-checking bench for mul_wb_buffer (DEPTH 4, TAG_W 5).
module tb_mul_wb_buffer;
  logic clk;
  logic rst_n;
  int   n_total;
  int   n_pass;
  int   next_issue;
  int   next_done;
  int   exp_head;

`ifdef MUL_WB_OP_CHECK_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  mul_wb_buffer_if #(.DEPTH(4), .TAG_W(5)) bus ();

  mul_wb_buffer #(.DEPTH(4), .TAG_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle();
    bus.issue_valid = 1'b0;
    bus.issue_tag   = '0;
    bus.issue_op    = 2'b00;
    bus.mul_done    = 1'b0;
    bus.mul_op      = 2'b00;
    bus.mul_p       = '0;
    bus.wb_ack      = 1'b0;
  endtask

  task automatic issue(input logic [4:0] tag, input logic [1:0] op);
    bus.issue_valid = 1'b1;
    bus.issue_tag   = tag;
    bus.issue_op    = op;
    tick();
    idle();
  endtask

  task automatic done(input logic [1:0] op, input logic [63:0] p);
    bus.mul_done = 1'b1;
    bus.mul_op   = op;
    bus.mul_p    = p;
    tick();
    idle();
  endtask

  task automatic ack();
    bus.wb_ack = 1'b1;
    tick();
    idle();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    idle();
    do_reset();
    check("rst_occ", 64'(bus.occupancy), 64'd0);
    check("rst_ready", 64'(bus.issue_ready), 64'd1);
    check("rst_wb_valid", 64'(bus.wb_valid), 64'd0);
    check("rst_op_err", 64'(bus.op_err), 64'd0);

    // Single MUL end to end
    issue(5'd3, 2'b00);
    check("t1_occ", 64'(bus.occupancy), 64'd1);
    check("t1_not_ready_yet", 64'(bus.wb_valid), 64'd0);
    tick();
    done(2'b00, 64'h00000002_FFFFFFFE);
    check("t1_wb_valid", 64'(bus.wb_valid), 64'd1);
    check("t1_wb_tag", 64'(bus.wb_tag), 64'd3);
    check("t1_wb_data", 64'(bus.wb_data), 64'hFFFFFFFE);
    tick();
    check("t1_hold_data", 64'(bus.wb_data), 64'hFFFFFFFE);
    ack();
    check("t1_occ_after", 64'(bus.occupancy), 64'd0);
    check("t1_wb_valid_after", 64'(bus.wb_valid), 64'd0);

    // High-half select for MULH/MULHSU/MULHU
    issue(5'd1, 2'b01);
    issue(5'd2, 2'b10);
    issue(5'd4, 2'b11);
    done(2'b01, 64'h12345678_9ABCDEF0);
    done(2'b10, 64'h12345678_9ABCDEF0);
    done(2'b11, 64'h12345678_9ABCDEF0);
    check("t2_occ", 64'(bus.occupancy), 64'd3);
    for (int i = 0; i < 3; i++) begin
      check("t2_wb_valid", 64'(bus.wb_valid), 64'd1);
      check("t2_wb_tag", 64'(bus.wb_tag), (i == 0) ? 64'd1 : (i == 1) ? 64'd2 : 64'd4);
      check("t2_wb_data", 64'(bus.wb_data), 64'h12345678);
      ack();
    end
    check("t2_occ_after", 64'(bus.occupancy), 64'd0);

    // Full and backpressure
    for (int i = 0; i < 4; i++) begin
      check("t3_ready_before_full", 64'(bus.issue_ready), 64'd1);
      issue(5'(10 + i), 2'b00);
    end
    check("t3_ready_full", 64'(bus.issue_ready), 64'd0);
    check("t3_occ_full", 64'(bus.occupancy), 64'd4);
    issue(5'd20, 2'b00);
    check("t3_occ_ignored", 64'(bus.occupancy), 64'd4);
    done(2'b00, 64'd10);
    check("t3_head_valid", 64'(bus.wb_valid), 64'd1);
    check("t3_head_tag", 64'(bus.wb_tag), 64'd10);
    bus.wb_ack = 1'b1;
    check("t3_no_passthru", 64'(bus.issue_ready), 64'd0);
    tick();
    idle();
    check("t3_ready_after_pop", 64'(bus.issue_ready), 64'd1);
    check("t3_occ_after_pop", 64'(bus.occupancy), 64'd3);
    for (int k = 11; k < 14; k++) begin
      done(2'b00, 64'(k));
      check("t3_drain_tag", 64'(bus.wb_tag), 64'(k));
      check("t3_drain_data", 64'(bus.wb_data), 64'(k));
      ack();
    end
    check("t3_drained_occ", 64'(bus.occupancy), 64'd0);
    check("t3_drained_valid", 64'(bus.wb_valid), 64'd0);

    // Issue, done and ack every cycle across pointer wrap
    issue(5'd0, 2'b00);
    bus.issue_valid = 1'b1;
    bus.issue_tag   = 5'd1;
    done(2'b00, 64'd0);
    next_issue = 2;
    next_done  = 1;
    exp_head   = 0;
    for (int c = 0; c < 20; c++) begin
      check("t4_occ", 64'(bus.occupancy), 64'd2);
      check("t4_wb_valid", 64'(bus.wb_valid), 64'd1);
      check("t4_wb_tag", 64'(bus.wb_tag), 64'(exp_head));
      check("t4_wb_data", 64'(bus.wb_data), 64'(exp_head));
      bus.issue_valid = 1'b1;
      bus.issue_tag   = 5'(next_issue);
      bus.mul_done    = 1'b1;
      bus.mul_op      = 2'b00;
      bus.mul_p       = 64'(next_done);
      bus.wb_ack      = 1'b1;
      tick();
      idle();
      next_issue++;
      next_done++;
      exp_head++;
    end
    check("t4_tail_tag", 64'(bus.wb_tag), 64'(exp_head));
    bus.mul_done = 1'b1;
    bus.mul_p    = 64'(next_done);
    ack();
    check("t4_last_tag", 64'(bus.wb_tag), 64'(next_done));
    check("t4_last_data", 64'(bus.wb_data), 64'(next_done));
    ack();
    check("t4_occ_end", 64'(bus.occupancy), 64'd0);

    // Reset mid-flight: stale completions dropped
    issue(5'd5, 2'b01);
    issue(5'd6, 2'b00);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    done(2'b01, 64'hAAAA_BBBB_CCCC_DDDD);
    done(2'b00, 64'hAAAA_BBBB_CCCC_DDDD);
    check("t5_wb_valid", 64'(bus.wb_valid), 64'd0);
    check("t5_occ", 64'(bus.occupancy), 64'd0);
    check("t5_op_err", 64'(bus.op_err), 64'(ERR_EXP));

    // Op mismatch: data still stored using mul_op for half selection
    do_reset();
    check("t6_err_cleared", 64'(bus.op_err), 64'd0);
    issue(5'd7, 2'b01);
    done(2'b00, 64'h12345678_9ABCDEF0);
    check("t6_op_err", 64'(bus.op_err), 64'(ERR_EXP));
    check("t6_wb_tag", 64'(bus.wb_tag), 64'd7);
    check("t6_wb_data", 64'(bus.wb_data), 64'h9ABCDEF0);
    ack();
    tick();
    check("t6_op_err_sticky", 64'(bus.op_err), 64'(ERR_EXP));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
